spi_slave: RTL and testbench
============================

# spi_slave

SPI responder for the PPG board's serial link. It answers an external SPI master on the same `sclk`/`spiste`/`spisimo`/`spisomi` wires. All pins are oversampled in the `div_clk` domain, and bytes are shifted MSB-first in mode 0: master drives on `sclk` low, sample on `sclk` rising. Received bytes go to the control logic with a one-cycle strobe, and transmit bytes come from a single-entry load buffer.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in each pin synchronizer (≥2).
- `div_clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from master; idles low.
- `spiste`  in  1  chip select, active low.
- `spisimo`  in  1  master-out data.
- `spisomi`  out  1  slave-out data.
- `tx_data`  in  8  next byte to send.
- `tx_load`  in  1  capture `tx_data` into tx buffer when `tx_ready`.
- `tx_ready`  out  1  tx buffer empty.
- `rx_data`  out  8  last complete received byte; held until next completion.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `busy`  out  1  high while frame active (synced `spiste` low).
- `frame_err`  out  1  one-cycle strobe: `spiste` rose mid-byte.

## Operation
- Reset values:
  - `spisomi`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=1, `busy`=0, `frame_err`=0.
  - bit_cnt=0, shifters=0, state IDLE.
- `sclk`, `spiste` and `spisimo` each pass through a SYNC_STAGES synchronizer. Rise/fall detection uses the last synced sample versus the previous one.
- IDLE (synced `spiste` high): `spisomi`=0, bit_cnt=0.
  - On `spiste` fall: go to SHIFT, `busy`=1.
  - Load tx_shift from the tx buffer if it is full, else 8'h00.
  - `spisomi`=tx_shift[7] immediately, so bit 7 is valid before the first `sclk` rise.
- SHIFT:
  - `sclk` rise: rx_shift <= {rx_shift[6:0], spisimo_s}; bit_cnt++.
  - `sclk` fall with bit_cnt in 1..7: tx_shift <<= 1, so `spisomi` shows the next bit.
  - `sclk` fall with bit_cnt==0 after a completed byte: reload tx_shift from the tx buffer, or 8'h00 if empty. Multi-byte frames are supported.
  - bit_cnt reaches 8 on a rise:
    - `rx_data` <= {rx_shift[6:0], spisimo_s}, `rx_valid`=1 for one cycle.
    - bit_cnt <= 0.
  - `spiste` rise: return to IDLE, `busy`=0.
    - If bit_cnt≠0: partial byte discarded, `frame_err` pulses, no `rx_valid`.
- tx buffer (single entry):
  - `tx_load` with `tx_ready`=1 captures `tx_data`; `tx_ready`=0 next cycle.
  - `tx_load` with `tx_ready`=0 is ignored.
  - Loading into tx_shift empties the buffer; `tx_ready`=1 next cycle.
  - Same cycle load and consume: the shifter takes the old buffer contents and the new byte fills the buffer.
- No rx backpressure. An unread `rx_data` is overwritten by the next byte.

## Timing
- Simultaneous events in one `div_clk` cycle:
  - 8th `sclk` rise and `spiste` rise: completion first, so `rx_valid` pulses and there is no `frame_err`. Then IDLE.
  - `sclk` rise and fall cannot both occur, given the edge-spacing rule below.
- `sclk` high and low phases must each be ≥ SYNC_STAGES+2 `div_clk` periods.
- `spiste` fall to first `sclk` rise must be ≥ SYNC_STAGES+2 periods.
- Latency, pin edge to effect, is SYNC_STAGES+1 cycles:
  - `sclk` rise → sample;
  - 8th rise → `rx_valid`;
  - `sclk` fall → `spisomi` change.
- `spisomi` is registered and glitch-free. It is stable from SYNC_STAGES+1 cycles after a fall until the next fall plus SYNC_STAGES+1.
- `rst_n` assertion mid-frame forces reset values at once. After release, the block waits in IDLE.
  - If `spiste` is already low, that is treated as a frame start. Sync history is reset to idle levels: `sclk`=0, `spiste`=1.

## Structure
- Package `spi_pkg`:
  - `SPI_BYTE_W`=8;
  - state enum {IDLE, SHIFT};
  - `SPI_SYNC_DEFAULT`=2.
- Sub-module `spi_sync`: parameterized synchronizer plus edge detector, with outputs level, rise and fall. Instantiated three times.
- Top: bit counter, two shifters, tx buffer, state register.

## Test plan
- Reset, then master sends 8'hA5 with `spiste` low → `rx_valid` one cycle, `rx_data`=8'hA5, `busy` high for the frame.
- `tx_load` 8'h3C before the frame, master clocks 8 bits → master captures 8'h3C on `spisomi`, `tx_ready` back to 1 after frame start.
- Two-byte frame: tx buffer 8'h11, reload 8'h22 during byte 1; master sends 8'hF0, 8'h0F → master reads 11,22; two `rx_valid` strobes with F0 then 0F.
- `spiste` raised after 5 bits → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, `spisomi`=0.
- Empty tx buffer at frame start → 8'h00 shifted out. `tx_load` while `tx_ready`=0 → ignored, buffer keeps first byte.
- `rst_n` pulsed low after 3 bits → all outputs at reset values. The next full frame of 8'h5A is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths, state encoding and byte/counter types for the SPI responder.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W       = 8;
  localparam int unsigned SPI_CNT_W        = $clog2(SPI_BYTE_W);
  localparam int unsigned SPI_SYNC_DEFAULT = 2;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
  typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

  // Counter value on the rise that completes a byte
  localparam spi_cnt_t SPI_LAST_BIT = spi_cnt_t'(SPI_BYTE_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Pin synchronizer with registered level and single-cycle rise/fall flags.
// rise/fall are produced on the same edge the synced level changes, so the
// consumer sees pin-edge-to-flag latency of STAGES cycles.
module spi_sync
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = SPI_SYNC_DEFAULT,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  assign level = chain[STAGES-1];

  // Shift the pin through the synchronizer and flag the edge as it emerges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      rise  <= chain[STAGES-2] & ~chain[STAGES-1];
      fall  <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, MSB-first rx/tx shifters,
// single-entry tx load buffer and a two-state frame FSM.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic                  div_clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  spiste,
  input  logic                  spisimo,
  output logic                  spisomi,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ste_lvl, ste_rise, ste_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_pins;

  state_t                  state, state_nxt;
  spi_cnt_t                bit_cnt;
  logic                    byte_done;
  logic [SPI_BYTE_W-2:0]   rx_shift;
  spi_byte_t               tx_shift;
  spi_byte_t               tx_buf;

  spi_byte_t               tx_src_c;
  spi_byte_t               rx_next_c;
  logic                    start_c, stop_c, sample_c, complete_c;
  logic                    abort_c, shift_c, reload_c, load_c;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (div_clk),
    .rst_n (rst_n),
    .pin   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ste (
    .clk   (div_clk),
    .rst_n (rst_n),
    .pin   (spiste),
    .level (ste_lvl),
    .rise  (ste_rise),
    .fall  (ste_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (div_clk),
    .rst_n (rst_n),
    .pin   (spisimo),
    .level (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // Only edges of sclk/spiste and the level of spisimo are consumed
  assign unused_pins = ^{sclk_lvl, ste_lvl, mosi_rise, mosi_fall};

  // Frame state register
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    stop_c     = 1'b0;
    sample_c   = 1'b0;
    complete_c = 1'b0;
    abort_c    = 1'b0;
    shift_c    = 1'b0;
    reload_c   = 1'b0;
    load_c     = tx_load & tx_ready;
    tx_src_c   = tx_ready ? '0 : tx_buf;
    rx_next_c  = {rx_shift, mosi_s};
    case (state)
      IDLE: begin
        if (ste_fall) begin
          start_c   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sample_c   = sclk_rise;
        complete_c = sclk_rise && (bit_cnt == SPI_LAST_BIT);
        if (ste_rise) begin
          // A byte completing on the same cycle wins over the abort
          stop_c    = 1'b1;
          abort_c   = (bit_cnt != '0) && !complete_c;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          if (bit_cnt != '0) shift_c  = 1'b1;
          else if (byte_done) reload_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter, shifters and registered outputs; later assignments take priority
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      spisomi   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (sample_c) begin
        rx_shift <= rx_next_c[SPI_BYTE_W-2:0];
        if (complete_c) begin
          rx_data   <= rx_next_c;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          byte_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + spi_cnt_t'(1);
        end
      end
      if (shift_c) begin
        tx_shift <= tx_shift << 1;
        spisomi  <= tx_shift[SPI_BYTE_W-2];
      end
      if (reload_c) begin
        tx_shift  <= tx_src_c;
        spisomi   <= tx_src_c[SPI_BYTE_W-1];
        byte_done <= 1'b0;
      end
      if (start_c) begin
        busy      <= 1'b1;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        rx_shift  <= '0;
        tx_shift  <= tx_src_c;
        spisomi   <= tx_src_c[SPI_BYTE_W-1];
      end
      if (stop_c) begin
        busy      <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        spisomi   <= 1'b0;
        frame_err <= abort_c;
      end
    end
  end

  // Single-entry tx buffer; a load only lands when empty, so a same-cycle
  // consume always takes the old (empty) contents
  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (load_c) begin
      tx_buf   <= tx_data;
      tx_ready <= 1'b0;
    end else if (start_c || reload_c) begin
      tx_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: a timed event model predicts every output
// per cycle, and a bit-banged master checks the bytes it reads back.
module tb_spi_slave;

  localparam int S = 2;

  logic       div_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sclk    = 1'b0;
  logic       spiste  = 1'b1;
  logic       spisimo = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       spisomi, tx_ready, rx_valid, busy, frame_err;
  logic [7:0] rx_data;

  spi_slave #(.SYNC_STAGES(S)) dut (
    .div_clk   (div_clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .spiste    (spiste),
    .spisimo   (spisimo),
    .spisomi   (spisomi),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 div_clk = ~div_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_strobes = 0;
  int err_strobes = 0;

  // Model state: output levels plus events keyed by the cycle they appear
  logic [7:0] rx_hold = 8'h00;
  bit         busy_m  = 1'b0;
  bit         rdy_m   = 1'b1;
  logic [7:0] exp_rx[int];
  bit         busy_evt[int];
  bit         rdy_evt[int];
  bit         err_evt[int];
  logic [7:0] mbuf = 8'h00;
  bit         mbuf_full = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] fd[4];
  logic [7:0] mg[4];
  bit         v_exp, e_exp;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled 1ns after the edge
  always @(posedge div_clk) begin
    #1;
    cyc++;
    if (rst_n) begin
      if (busy_evt.exists(cyc)) begin busy_m = busy_evt[cyc]; busy_evt.delete(cyc); end
      if (rdy_evt.exists(cyc))  begin rdy_m = rdy_evt[cyc];   rdy_evt.delete(cyc);  end
      v_exp = 1'b0;
      if (exp_rx.exists(cyc)) begin v_exp = 1'b1; rx_hold = exp_rx[cyc]; exp_rx.delete(cyc); end
      e_exp = err_evt.exists(cyc);
      if (e_exp) err_evt.delete(cyc);
      rx_strobes  += int'(rx_valid);
      err_strobes += int'(frame_err);
      chk("rx_valid", 8'(rx_valid), 8'(v_exp));
      chk("rx_data", rx_data, rx_hold);
      chk("busy", 8'(busy), 8'(busy_m));
      chk("frame_err", 8'(frame_err), 8'(e_exp));
      chk("tx_ready", 8'(tx_ready), 8'(rdy_m));
      if (!busy_m) chk("spisomi_idle", 8'(spisomi), 8'h00);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge div_clk);
  endtask

  function automatic int ph();
    return int'($urandom_range(S + 5, S + 2));
  endfunction

  task automatic model_reset();
    rx_hold = 8'h00; busy_m = 1'b0; rdy_m = 1'b1; mbuf_full = 1'b0;
    exp_rx.delete(); busy_evt.delete(); rdy_evt.delete(); err_evt.delete();
    exp_tx.delete();
  endtask

  // One-cycle tx_load pulse; accepted only when the buffer reads empty
  task automatic try_load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    if (rdy_m) begin
      mbuf = v; mbuf_full = 1'b1; rdy_evt[cyc + 1] = 1'b0;
    end
    @(negedge div_clk);
    tx_load = 1'b0;
  endtask

  // Buffer handed to the shifter: the byte the master will read next
  task automatic consume();
    exp_tx.push_back(mbuf_full ? mbuf : 8'h00);
    if (mbuf_full) begin
      mbuf_full = 1'b0;
      rdy_evt[cyc + S + 1] = 1'b1;
    end
  endtask

  task automatic frame_start();
    spiste = 1'b0;
    busy_evt[cyc + S + 1] = 1'b1;
    consume();
  endtask

  task automatic frame_end(input int bits_pending);
    step(ph());
    spiste = 1'b1;
    busy_evt[cyc + S + 1] = 1'b0;
    if (bits_pending != 0) err_evt[cyc + S + 1] = 1'b1;
    exp_tx.delete();
    step(S + 4);
  endtask

  // Clock out nbits of b MSB-first while capturing spisomi on each rise
  task automatic send_byte(input logic [7:0] b, input int nbits, input int load_at,
                           input logic [7:0] load_v, input bit ste_last,
                           output logic [7:0] got);
    int n;
    bit done;
    got = 8'h00;
    done = 1'b0;
    for (int i = 0; i < nbits && !done; i++) begin
      spisimo = b[3'(7 - i)];
      step(ph());
      sclk = 1'b1;
      got = {got[6:0], spisomi};
      if (i == 7) exp_rx[cyc + S + 1] = b;
      if (i == 7 && ste_last) begin
        spiste = 1'b1;
        busy_evt[cyc + S + 1] = 1'b0;
        done = 1'b1;
      end else begin
        n = ph();
        if (i == load_at) begin
          try_load(load_v);
          n--;
        end
        step(n);
        sclk = 1'b0;
        if (i == 7) consume();
      end
    end
  endtask

  task automatic do_frame(input int nbytes, input int abort_bits, input int load_byte,
                          input logic [7:0] load_v, input bit ste_last);
    logic [7:0] g;
    frame_start();
    for (int j = 0; j < nbytes; j++) begin
      send_byte(fd[j], 8, (j == load_byte) ? 3 : -1, load_v, ste_last && (j == nbytes - 1), g);
      mg[j] = g;
      chk("miso_byte", g, exp_tx.pop_front());
    end
    if (abort_bits > 0) begin
      send_byte(fd[nbytes], abort_bits, -1, 8'h00, 1'b0, g);
      frame_end(abort_bits);
    end else if (ste_last) begin
      step(ph());
      sclk = 1'b0;
      exp_tx.delete();
      step(S + 4);
    end else begin
      frame_end(0);
    end
  endtask

  initial begin
    int rs, es, nb, ab, lb;
    bit sl;
    logic [7:0] g;

    // Reset values
    step(4);
    #1;
    chk("rst_spisomi", 8'(spisomi), 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", 8'(rx_valid), 8'h00);
    chk("rst_tx_ready", 8'(tx_ready), 8'h01);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_frame_err", 8'(frame_err), 8'h00);
    @(negedge div_clk);
    rst_n = 1'b1;
    step(S + 4);

    // Plain receive of A5 with an empty tx buffer
    rs = rx_strobes;
    fd[0] = 8'hA5;
    do_frame(1, 0, -1, 8'h00, 1'b0);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_strobes", 8'(rx_strobes - rs), 8'h01);
    chk("a5_miso", mg[0], 8'h00);

    // Preloaded 3C is shifted out; buffer frees at frame start
    try_load(8'h3C);
    step(S + 3);
    chk("3c_ready_before", 8'(tx_ready), 8'h00);
    fd[0] = 8'h69;
    do_frame(1, 0, -1, 8'h00, 1'b0);
    chk("3c_miso", mg[0], 8'h3C);
    chk("3c_ready_after", 8'(tx_ready), 8'h01);

    // Two-byte frame with a reload during byte 1
    try_load(8'h11);
    step(S + 3);
    rs = rx_strobes;
    fd[0] = 8'hF0; fd[1] = 8'h0F;
    do_frame(2, 0, 0, 8'h22, 1'b0);
    chk("two_miso0", mg[0], 8'h11);
    chk("two_miso1", mg[1], 8'h22);
    chk("two_rx_last", rx_data, 8'h0F);
    chk("two_strobes", 8'(rx_strobes - rs), 8'h02);

    // Abort after 5 bits
    rs = rx_strobes; es = err_strobes;
    fd[0] = 8'hC7;
    do_frame(0, 5, -1, 8'h00, 1'b0);
    chk("abort_err", 8'(err_strobes - es), 8'h01);
    chk("abort_no_rx", 8'(rx_strobes - rs), 8'h00);
    chk("abort_rx_kept", rx_data, 8'h0F);
    chk("abort_spisomi", 8'(spisomi), 8'h00);

    // Second load while full is ignored; following frame with empty buffer sends 00
    try_load(8'hAA);
    try_load(8'hBB);
    step(S + 3);
    fd[0] = 8'h3E;
    do_frame(1, 0, -1, 8'h00, 1'b0);
    chk("ignore_miso", mg[0], 8'hAA);
    fd[0] = 8'h81;
    do_frame(1, 0, -1, 8'h00, 1'b0);
    chk("empty_miso", mg[0], 8'h00);

    // 8th rise together with spiste rise: completion, no frame error
    rs = rx_strobes; es = err_strobes;
    fd[0] = 8'h96;
    do_frame(1, 0, -1, 8'h00, 1'b1);
    chk("simul_rx", rx_data, 8'h96);
    chk("simul_strobe", 8'(rx_strobes - rs), 8'h01);
    chk("simul_no_err", 8'(err_strobes - es), 8'h00);

    // Reset after 3 bits with spiste held low; release acts as a frame start
    frame_start();
    send_byte(8'hC3, 3, 1, 8'h77, 1'b0, g);
    @(negedge div_clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_spisomi", 8'(spisomi), 8'h00);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_tx_ready", 8'(tx_ready), 8'h01);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_rx_valid", 8'(rx_valid), 8'h00);
    chk("mid_rst_frame_err", 8'(frame_err), 8'h00);
    model_reset();
    step(3);
    rst_n = 1'b1;
    busy_evt[cyc + S + 1] = 1'b1;
    consume();
    send_byte(8'h5A, 8, -1, 8'h00, 1'b0, g);
    chk("post_rst_miso", g, exp_tx.pop_front());
    frame_end(0);
    chk("post_rst_rx", rx_data, 8'h5A);
    chk("post_rst_miso_lit", g, 8'h00);

    // Randomized frames
    for (int r = 0; r < 25; r++) begin
      nb = int'($urandom_range(3, 1));
      ab = ($urandom % 4 == 0) ? int'($urandom_range(7, 1)) : 0;
      lb = int'($urandom % 3);
      sl = (ab == 0) && ($urandom % 5 == 0);
      for (int k = 0; k < 4; k++) fd[k] = 8'($urandom);
      if ($urandom % 2 == 0) begin
        try_load(8'($urandom));
        step(S + 3);
      end
      do_frame(nb, ab, lb, 8'($urandom), sl);
    end

    step(S + 6);
    chk("events_drained", 8'(exp_rx.num() + err_evt.num() + busy_evt.num() + rdy_evt.num()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
